// File: rtl/systolic_drain.sv
// Snapshots an NxN accumulator array on start and streams it out row-major
// over a valid/ready port, pulsing acc_clr once per drain and done at the end.
module systolic_drain #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 4,
    localparam int unsigned IDXW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [N*N*DATA_WIDTH-1:0]    c_flat,
    output logic                         acc_clr,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDXW-1:0]              out_row,
    output logic [IDXW-1:0]              out_col,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [DATA_WIDTH-1:0] r_buf [N][N];
    logic [IDXW-1:0]       r_row;
    logic [IDXW-1:0]       r_col;
    logic                  r_acc_clr;

    logic                  w_start_ok;
    logic                  w_fire;
    logic                  w_at_end;

    assign w_start_ok = (r_state == IDLE) && start;
    assign w_fire     = (r_state == STREAM) && out_ready;
    assign w_at_end   = (r_row == IDXW'(N - 1)) && (r_col == IDXW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = STREAM;
            STREAM:  if (w_fire && w_at_end) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The linear index is kept as a (row, col) pair so out_row/out_col need no
    // divider; it stops at (N-1, N-1) and is only rewound by a new start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row     <= '0;
            r_col     <= '0;
            r_acc_clr <= 1'b0;
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    r_buf[i][j] <= '0;
                end
            end
        end else begin
            r_acc_clr <= w_start_ok;
            if (w_start_ok) begin
                r_row <= '0;
                r_col <= '0;
                for (int unsigned i = 0; i < N; i++) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        r_buf[i][j] <= c_flat[(i*N + j)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end else if (w_fire && !w_at_end) begin
                if (r_col == IDXW'(N - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign acc_clr   = r_acc_clr;
    assign out_data  = r_buf[r_row][r_col];
    assign out_row   = r_row;
    assign out_col   = r_col;
    assign out_valid = (r_state == STREAM);
    assign out_last  = (r_state == STREAM) && w_at_end;
    assign busy      = (r_state == STREAM) || (r_state == DONE);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_systolic_drain.sv
// Randomised self-checking bench for systolic_drain (N=2, DATA_WIDTH=8),
// checked against an element-list model of the row-major drain.
module tb_systolic_drain;

    localparam int unsigned N  = 2;
    localparam int unsigned DW = 8;
    localparam int unsigned NN = N * N;
    localparam int unsigned W  = NN * DW;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    localparam int M_NORM  = 0;
    localparam int M_STALL = 1;
    localparam int M_SNAP  = 2;
    localparam int M_IGN   = 3;
    localparam int M_RAND  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  c_flat;
    logic          acc_clr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_row;
    logic [IW-1:0] out_col;
    logic          out_last;
    logic          busy;
    logic          done;

    int tests = 0;
    int fails = 0;

    systolic_drain #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .c_flat    (c_flat),
        .acc_clr   (acc_clr),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; c_flat = '0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset/valid got %b want 0", out_valid); end
        tests++; if (out_data !== '0)    begin fails++; $display("FAIL reset/data got %h want 00", out_data); end
        tests++; if (out_row !== '0 || out_col !== '0) begin fails++; $display("FAIL reset/idx got %0d,%0d want 0,0", out_row, out_col); end
        tests++; if ({acc_clr, out_last, busy, done} !== 4'b0000) begin fails++; $display("FAIL reset/flags got %b want 0000", {acc_clr, out_last, busy, done}); end
        // start while held in reset must not be acted on
        c_flat = W'($urandom); start = 1'b1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if ({out_valid, acc_clr, busy} !== 3'b000) begin fails++; $display("FAIL reset/start_in_rst got %b want 000", {out_valid, acc_clr, busy}); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset/buf_in_rst got %h want 00", out_data); end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        tests++; if ({out_valid, busy, done} !== 3'b000) begin fails++; $display("FAIL reset/idle_after got %b want 000", {out_valid, busy, done}); end
    endtask

    // One complete drain of img from IDLE, checked every cycle against the
    // row-major element list; mode selects the ready/start/c_flat disturbance.
    task automatic drain(input string name, input logic [W-1:0] img, input int mode);
        int            k      = 0;
        int            cyc    = 0;
        int            stalls = 0;
        logic          rdy;
        logic [DW-1:0] e;
        logic [IW-1:0] er;
        logic [IW-1:0] ec;
        c_flat = img; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        while (k < NN && cyc < 100) begin
            e  = img[k*DW +: DW];
            er = IW'(k / N);
            ec = IW'(k % N);
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL %s/valid k=%0d got %b want 1", name, k, out_valid); end
            tests++; if (out_data !== e) begin fails++; $display("FAIL %s/data k=%0d got %h want %h", name, k, out_data, e); end
            tests++; if (out_row !== er || out_col !== ec) begin fails++; $display("FAIL %s/idx k=%0d got %0d,%0d want %0d,%0d", name, k, out_row, out_col, er, ec); end
            tests++; if (out_last !== (k == NN - 1)) begin fails++; $display("FAIL %s/last k=%0d got %b want %b", name, k, out_last, (k == NN - 1)); end
            tests++; if (acc_clr !== (cyc == 0)) begin fails++; $display("FAIL %s/acc_clr cyc=%0d got %b want %b", name, cyc, acc_clr, (cyc == 0)); end
            tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL %s/busy_done cyc=%0d got %b%b want 10", name, cyc, busy, done); end
            if (mode == M_SNAP && cyc == 0) c_flat = '1;
            start = (mode == M_IGN && cyc == 1);
            if (mode == M_STALL) begin
                rdy = !(k == 1 && stalls < 3);
                if (!rdy) stalls++;
            end else if (mode == M_RAND) begin
                rdy = 1'($urandom_range(0, 1));
            end else begin
                rdy = 1'b1;
            end
            out_ready = rdy;
            @(posedge clk); @(negedge clk);
            if (rdy) k++;
            cyc++;
        end
        start = 1'b0;
        tests++; if (k < NN) begin fails++; $display("FAIL %s/timeout transfers got %0d want %0d", name, k, NN); end
        tests++; if ({out_valid, done, busy, acc_clr} !== 4'b0110) begin fails++; $display("FAIL %s/done_cycle got %b want 0110", name, {out_valid, done, busy, acc_clr}); end
        if (mode == M_IGN) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        tests++; if ({out_valid, done, busy, acc_clr, out_last} !== 5'b00000) begin fails++; $display("FAIL %s/idle got %b want 00000", name, {out_valid, done, busy, acc_clr, out_last}); end
        tests++; if (out_data !== img[(NN-1)*DW +: DW]) begin fails++; $display("FAIL %s/idle_hold got %h want %h", name, out_data, img[(NN-1)*DW +: DW]); end
        @(negedge clk);
        tests++; if ({out_valid, busy, acc_clr} !== 3'b000) begin fails++; $display("FAIL %s/stay_idle got %b want 000", name, {out_valid, busy, acc_clr}); end
    endtask

    task automatic test_basic();
        drain("basic", 32'h04030201, M_NORM);
    endtask

    task automatic test_backpressure();
        drain("backpressure", 32'h04030201, M_STALL);
    endtask

    task automatic test_snapshot();
        drain("snapshot", 32'h04030201, M_SNAP);
    endtask

    task automatic test_ignored_start();
        drain("ignored_start", 32'h04030201, M_IGN);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] img;
        img = W'($urandom);
        c_flat = img; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++; if (out_valid !== 1'b1 || out_data !== img[2*DW +: DW]) begin fails++; $display("FAIL reset_mid/pre got %b %h want 1 %h", out_valid, out_data, img[2*DW +: DW]); end
        rst = 1'b1;
        #1;
        tests++; if ({out_valid, busy, done, acc_clr, out_last} !== 5'b00000) begin fails++; $display("FAIL reset_mid/async got %b want 00000", {out_valid, busy, done, acc_clr, out_last}); end
        tests++; if (out_data !== '0 || out_row !== '0 || out_col !== '0) begin fails++; $display("FAIL reset_mid/clear got %h %0d,%0d want 00 0,0", out_data, out_row, out_col); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++; if (done !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("FAIL reset_mid/after cyc=%0d got %b%b want 00", i, done, out_valid); end
        end
        drain("reset_mid_redo", W'($urandom), M_NORM);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            drain("random", W'($urandom), M_RAND);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_ignored_start();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_drain.md
SYSTOLIC_DRAIN -- requirements
Module: systolic_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of one result element.
REQ-002 Parameter N, default 4, array dimension; the block drains N*N results.
REQ-003 The block SHALL have the following ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle request to snapshot and drain the array.
- c_flat  input  N*N*DATA_WIDTH  all PE accumulator outputs; element (i,j) at bits [(i*N+j)*DATA_WIDTH +: DATA_WIDTH].
- acc_clr  output  1  one-cycle pulse telling the array to clear its accumulators.
- out_data  output  DATA_WIDTH  current result element.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  downstream accepts the element.
- out_row  output  clog2(N) (min 1)  row index i of out_data.
- out_col  output  clog2(N) (min 1)  column index j of out_data.
- out_last  output  1  high with the element (N-1,N-1).
- busy  output  1  high in STREAM and DONE.
- done  output  1  one-cycle pulse after the final handshake.

Function
REQ-004 FSM states: IDLE, STREAM, DONE; all outputs registered or decoded from registered state.
REQ-005 IDLE: start=1 at an edge -> copy all N*N elements of c_flat into an internal buffer, index counter := 0, acc_clr := 1 for the next cycle, state := STREAM.
REQ-006 Latency: out_valid SHALL be 1 in the cycle immediately after the start edge.
REQ-007 acc_clr SHALL be high for exactly one cycle per accepted start, in the first STREAM cycle.
REQ-008 STREAM: out_valid=1; out_data=buffer[counter]; out_row=counter/N; out_col=counter%N; out_last=(counter==N*N-1).
REQ-009 Transfer occurs only on an edge where out_valid=1 and out_ready=1; counter increments by 1 per transfer, row-major order.
REQ-010 out_ready=0 in STREAM -> out_data, out_row, out_col, out_last, counter held stable (no drop, no repeat).
REQ-011 Transfer with out_last=1 -> state := DONE, out_valid := 0 next cycle; counter SHALL never exceed N*N-1 (no wrap).
REQ-012 DONE: done=1 for exactly one cycle, out_valid=0, then state := IDLE.
REQ-013 start while in STREAM or DONE SHALL be ignored (no re-snapshot, no acc_clr).
REQ-014 Buffer contents SHALL be unaffected by c_flat changes after the snapshot edge.
REQ-015 out_data is a direct copy of the captured element; no arithmetic, truncation or sign handling.
REQ-016 IDLE: out_valid=0, out_last=0, busy=0, done=0, acc_clr=0; out_data holds last driven value.
REQ-017 start and the final transfer can never coincide in IDLE; start in the DONE cycle is ignored and must be reissued in IDLE.

Reset
REQ-018 rst=1 SHALL immediately (asynchronously) force state=IDLE, counter=0, out_data=0, out_row=0, out_col=0, out_valid=0, out_last=0, acc_clr=0, busy=0, done=0; buffer cleared to 0.
REQ-019 rst asserted mid-STREAM SHALL abort the drain; no done pulse; after release the block waits for a new start.

Verification (N=2, DATA_WIDTH=8)
REQ-020 Basic drain: c_flat={8'h04,8'h03,8'h02,8'h01}, start pulse, out_ready=1 -> outputs 01(0,0),02(0,1),03(1,0),04(1,1,last) on 4 consecutive cycles starting 1 cycle after start, acc_clr 1 cycle, done 1 cycle after last.
REQ-021 Backpressure: same data, out_ready low 3 cycles while 02 presented -> 02 held stable with (0,1), then 03,04 follow; no element lost or duplicated.
REQ-022 Snapshot isolation: change c_flat to all 8'hFF one cycle after start -> stream still 01,02,03,04.
REQ-023 Ignored start: pulse start during STREAM and in DONE -> no extra acc_clr, sequence and done count unchanged.
REQ-024 Reset mid-operation: assert rst after 2nd transfer -> out_valid=0 immediately, no done; new start after release drains fresh snapshot from index 0.
